sa_job_sequencer: RTL and testbench

Sequences one complete N×N matrix-multiply job on the systolic array datapath: PE clear, element-wise loading of the A and B shift buffers, the timed compute/shift phase, and row-by-row result drain with backpressure. The host side sees a start/busy/done job interface plus a valid/ready element stream. The array side sees the load, shift, position and row-select strobes consumed by the shift buffers and PE array. It replaces free-running sequencing with an abortable, backpressure-aware FSM.

---
 rtl/sa_job_sequencer_pkg.sv | 37 +++
 rtl/sa_job_sequencer_if.sv | 38 +++
 rtl/sa_job_sequencer_step_counter.sv | 30 +++
 rtl/sa_job_sequencer.sv | 143 ++++++++++++++
 tb/tb_sa_job_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/sa_job_sequencer_pkg.sv
// Shared types and sizing constants for the systolic-array job sequencer.
// The wrapper and PE array import the same definitions.
package sa_pkg;

  localparam int N              = 4;
  localparam int DATA_W         = 8;
  localparam int ROW_W          = 2;
  localparam int ID_W           = 3;
  localparam int COMPUTE_CYCLES = 3 * N - 2;

  localparam int K_W = 4;
  localparam int C_W = 4;
  localparam int R_W = 2;

  localparam logic [K_W-1:0] K_LAST = K_W'(N * N - 1);
  localparam logic [C_W-1:0] C_LAST = C_W'(COMPUTE_CYCLES - 1);
  localparam logic [R_W-1:0] R_LAST = R_W'(N - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } sa_state_t;

  // Row-major split of the element index: row = k / N, slot = k % N.
  function automatic logic [ROW_W-1:0] row_of(input logic [K_W-1:0] k);
    return k[K_W-1:2];
  endfunction

  function automatic logic [ID_W-1:0] slot_of(input logic [K_W-1:0] k);
    return {1'b0, k[1:0]};
  endfunction

endpackage

// File: rtl/sa_job_sequencer_if.sv
// Host job/stream handshake plus the strobes driven into the shift buffers and PE array.
interface sa_job_sequencer_if;
  import sa_pkg::*;

  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             in_valid;
  logic             in_ready;
  logic             load_A;
  logic             load_B;
  logic [ROW_W-1:0] row_A;
  logic [ROW_W-1:0] row_B;
  logic [ID_W-1:0]  id_A;
  logic [ID_W-1:0]  id_B;
  logic             shift;
  logic             pe_clr;
  logic             output_sign;
  logic [ROW_W-1:0] row_out;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    input  start, abort, in_valid, out_ready,
    output busy, done, aborted, in_ready, load_A, load_B, row_A, row_B,
           id_A, id_B, shift, pe_clr, output_sign, row_out, out_valid, out_last
  );

  modport slave (
    output start, abort, in_valid, out_ready,
    input  busy, done, aborted, in_ready, load_A, load_B, row_A, row_B,
           id_A, id_B, shift, pe_clr, output_sign, row_out, out_valid, out_last
  );

endinterface

// File: rtl/sa_job_sequencer_step_counter.sv
// Clearable up-counter that advances on enable and saturates at LAST.
module sa_step_counter #(
  parameter int           W    = 4,
  parameter logic [W-1:0] LAST = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count register: clear wins over enable, holds once LAST is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {W{1'b0}};
    end else if (i_clr) begin
      r_count <= {W{1'b0}};
    end else if (i_en && (r_count != LAST)) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/sa_job_sequencer.sv
// Abortable, backpressure-aware sequencer for one N x N systolic matrix-multiply job:
// clear, element load, timed compute shift, then row-by-row result drain.
module sa_job_sequencer
  import sa_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  sa_job_sequencer_if.master   bus
);

  sa_state_t      r_state;
  sa_state_t      w_next;
  logic           r_aborted;
  logic [K_W-1:0] w_k;
  logic [C_W-1:0] w_c;
  logic [R_W-1:0] w_r;
  logic           w_clr;
  logic           w_load_hs;
  logic           w_drain_hs;
  logic           w_compute;

  assign w_clr      = (r_state == ST_CLEAR);
  assign w_compute  = (r_state == ST_COMPUTE);
  assign w_load_hs  = (r_state == ST_LOAD) && bus.in_valid;
  assign w_drain_hs = (r_state == ST_DRAIN) && bus.out_ready;

  sa_step_counter #(.W(K_W), .LAST(K_LAST)) u_k_cnt (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(w_load_hs), .o_count(w_k)
  );

  sa_step_counter #(.W(C_W), .LAST(C_LAST)) u_c_cnt (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(w_compute), .o_count(w_c)
  );

  sa_step_counter #(.W(R_W), .LAST(R_LAST)) u_r_cnt (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(w_drain_hs), .o_count(w_r)
  );

  // State register plus the one-cycle abort marker shown in the following IDLE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_aborted <= (r_state != ST_IDLE) && bus.abort;
    end
  end

  // Next-state logic; abort overrides every transition, including the final drain beat.
  always_comb begin
    w_next = r_state;
    if ((r_state != ST_IDLE) && bus.abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) w_next = ST_CLEAR;
          else           w_next = ST_IDLE;
        end
        ST_CLEAR: w_next = ST_LOAD;
        ST_LOAD: begin
          if (w_load_hs && (w_k == K_LAST)) w_next = ST_COMPUTE;
          else                              w_next = ST_LOAD;
        end
        ST_COMPUTE: begin
          if (w_c == C_LAST) w_next = ST_DRAIN;
          else               w_next = ST_COMPUTE;
        end
        ST_DRAIN: begin
          if (w_drain_hs && (w_r == R_LAST)) w_next = ST_DONE;
          else                               w_next = ST_DRAIN;
        end
        ST_DONE: w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Output decode from registered state/counters and the live in_valid/out_ready.
  always_comb begin
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.aborted     = r_aborted;
    bus.in_ready    = 1'b0;
    bus.load_A      = 1'b0;
    bus.load_B      = 1'b0;
    bus.row_A       = {ROW_W{1'b0}};
    bus.row_B       = {ROW_W{1'b0}};
    bus.id_A        = {ID_W{1'b0}};
    bus.id_B        = {ID_W{1'b0}};
    bus.shift       = 1'b0;
    bus.pe_clr      = r_aborted;
    bus.output_sign = 1'b0;
    bus.row_out     = {ROW_W{1'b0}};
    bus.out_valid   = 1'b0;
    bus.out_last    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.busy = 1'b0;
      end
      ST_CLEAR: begin
        bus.busy   = 1'b1;
        bus.pe_clr = 1'b1;
      end
      ST_LOAD: begin
        bus.busy     = 1'b1;
        bus.in_ready = 1'b1;
        // Position lines carry the element index only on an accepted beat.
        if (bus.in_valid) begin
          bus.load_A = 1'b1;
          bus.load_B = 1'b1;
          bus.row_A  = row_of(w_k);
          bus.row_B  = row_of(w_k);
          bus.id_A   = slot_of(w_k);
          bus.id_B   = slot_of(w_k);
        end else begin
          bus.load_A = 1'b0;
          bus.load_B = 1'b0;
        end
      end
      ST_COMPUTE: begin
        bus.busy  = 1'b1;
        bus.shift = 1'b1;
      end
      ST_DRAIN: begin
        bus.busy        = 1'b1;
        bus.output_sign = 1'b1;
        bus.out_valid   = 1'b1;
        bus.row_out     = w_r;
        bus.out_last    = (w_r == R_LAST);
      end
      ST_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sa_job_sequencer.sv
// Self-checking bench for sa_job_sequencer: directed vector table, scripted corner-case jobs
// and randomized jobs checked every cycle against a progress-count job model.
module tb_sa_job_sequencer;
  import sa_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sa_job_sequencer_if b();
  sa_job_sequencer dut (.clk(clk), .rst(rst), .bus(b.master));

  int n_checks = 0;
  int n_fail   = 0;

  // Job model: a job is "how far it has got" in each phase, not a state machine.
  bit m_active, m_cleared, m_abpend;
  int m_loads, m_shifts, m_rows;

  int cur_cyc, snap_at;
  logic [22:0] snap_vec;
  int obs_loads, obs_bad_load, obs_order_bad, obs_shifts, obs_rows;
  int obs_dones, obs_done_cyc, obs_aborts, obs_stall2;

  typedef struct {
    logic       rst, start, abort, iv;
    logic [9:0] exp;   // {busy, pe_clr, in_ready, load, row[1:0], id[2:0], aborted}
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cur_cyc, act, exp);
    end
  endtask

  function automatic logic [22:0] dut_vec();
    return {b.busy, b.done, b.aborted, b.in_ready, b.load_A, b.load_B, b.row_A, b.row_B,
            b.id_A, b.id_B, b.shift, b.pe_clr, b.output_sign, b.row_out, b.out_valid, b.out_last};
  endfunction

  function automatic logic [22:0] model_vec();
    logic lo, ld, cp, dr, dn;
    logic [1:0] row, rout;
    logic [2:0] id;
    lo   = m_active && m_cleared && (m_loads < 16);
    cp   = m_active && m_cleared && (m_loads == 16) && (m_shifts < 10);
    dr   = m_active && m_cleared && (m_loads == 16) && (m_shifts == 10) && (m_rows < 4);
    dn   = m_active && m_cleared && (m_loads == 16) && (m_shifts == 10) && (m_rows == 4);
    ld   = lo && b.in_valid;
    row  = ld ? 2'(m_loads / 4) : 2'd0;
    id   = ld ? 3'(m_loads % 4) : 3'd0;
    rout = dr ? 2'(m_rows) : 2'd0;
    return {m_active, dn, m_abpend, lo, ld, ld, row, row, id, id, cp,
            (m_active && !m_cleared) || m_abpend, dr, rout, dr, dr && (m_rows == 3)};
  endfunction

  function automatic void model_update();
    if (rst) begin
      m_active = 1'b0; m_cleared = 1'b0; m_abpend = 1'b0;
      m_loads = 0; m_shifts = 0; m_rows = 0;
    end else if (m_active && b.abort) begin
      m_active = 1'b0;
      m_abpend = 1'b1;
    end else begin
      m_abpend = 1'b0;
      if (!m_active) begin
        if (b.start) begin
          m_active = 1'b1; m_cleared = 1'b0;
          m_loads = 0; m_shifts = 0; m_rows = 0;
        end
      end else if (!m_cleared) m_cleared = 1'b1;
      else if (m_loads < 16) begin if (b.in_valid) m_loads++; end
      else if (m_shifts < 10) m_shifts++;
      else if (m_rows < 4) begin if (b.out_ready) m_rows++; end
      else m_active = 1'b0;
    end
  endfunction

  task automatic step_check(input bit chk);
    @(negedge clk);
    if (chk) check("cycle_outputs", 32'(dut_vec()), 32'(model_vec()));
    if (b.load_A) begin
      if (!(b.in_valid && b.in_ready)) obs_bad_load++;
      if ({b.row_A, b.id_A} != {2'(obs_loads / 4), 3'(obs_loads % 4)}) obs_order_bad++;
      obs_loads++;
    end
    if (b.shift) obs_shifts++;
    if (b.out_valid && b.out_ready) begin
      if (b.row_out != 2'(obs_rows)) obs_order_bad++;
      if (b.out_last != (obs_rows == 3)) obs_order_bad++;
      obs_rows++;
    end
    if (b.out_valid && !b.out_ready && (b.row_out == 2'd2)) obs_stall2++;
    if (b.done) begin obs_dones++; obs_done_cyc = cur_cyc; end
    if (b.aborted) obs_aborts++;
    if (cur_cyc == snap_at) snap_vec = dut_vec();
  endtask

  task automatic step_adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // cycle 0 presents start; the first busy cycle is cycle 1.
  task automatic run_job(input int mode, input int abort_at, input int rst_at,
                         input bit hold_start, input int budget);
    obs_loads = 0; obs_bad_load = 0; obs_order_bad = 0; obs_shifts = 0; obs_rows = 0;
    obs_dones = 0; obs_done_cyc = -1; obs_aborts = 0; obs_stall2 = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      cur_cyc = cyc;
      b.start = hold_start ? (cyc < rst_at) : (cyc == 0);
      b.abort = (cyc == abort_at);
      rst     = (cyc == rst_at);
      case (mode)
        0: begin b.in_valid = 1'b1; b.out_ready = 1'b1; end
        1: begin b.in_valid = (cyc % 2 == 0); b.out_ready = 1'b1; end
        2: begin b.in_valid = 1'b1; b.out_ready = !(cyc >= 30 && cyc <= 32); end
        3: begin
          b.in_valid  = ($urandom_range(0, 3) != 0);
          b.out_ready = ($urandom_range(0, 2) != 0);
        end
        default: begin b.in_valid = 1'b1; b.out_ready = 1'b1; end
      endcase
      step_check(1'b1);
      step_adv();
    end
    b.start = 1'b0; b.abort = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; b.start = 1'b0; b.abort = 1'b0; b.in_valid = 1'b0; b.out_ready = 1'b1;
    cur_cyc = -1; snap_at = -1; snap_vec = 23'd0;
    repeat (2) begin step_check(1'b0); step_adv(); end

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'b0_0_0_0_00_000_0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10'b0_0_0_0_00_000_0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10'b0_0_0_0_00_000_0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10'b0_0_0_0_00_000_0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10'b0_0_0_0_00_000_0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10'b1_1_0_0_00_000_0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10'b1_0_1_0_00_000_0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10'b1_0_1_1_00_000_0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10'b1_0_1_1_00_001_0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'b1_0_1_1_00_010_0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'b0_1_0_0_00_000_1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'b0_0_0_0_00_000_0};
    for (int i = 0; i < 12; i++) begin
      cur_cyc = 100 + i;
      rst = tbl[i].rst; b.start = tbl[i].start; b.abort = tbl[i].abort; b.in_valid = tbl[i].iv;
      step_check(1'b1);
      check("table", 32'({b.busy, b.pe_clr, b.in_ready, b.load_A, b.row_A, b.id_A, b.aborted}),
            32'(tbl[i].exp));
      step_adv();
    end
    rst = 1'b0; b.abort = 1'b0; b.in_valid = 1'b0;

    // Full job with no stalls.
    run_job(0, -1, -1, 1'b0, 40);
    check("full_loads", obs_loads, 16);
    check("full_load_hs", obs_bad_load, 0);
    check("full_order", obs_order_bad, 0);
    check("full_shifts", obs_shifts, 10);
    check("full_rows", obs_rows, 4);
    check("full_done_cyc", obs_done_cyc, 32);
    check("full_done_cnt", obs_dones, 1);

    // Alternating in_valid gaps: LOAD stretches by 15 cycles.
    run_job(1, -1, -1, 1'b0, 60);
    check("gap_loads", obs_loads, 16);
    check("gap_load_hs", obs_bad_load, 0);
    check("gap_order", obs_order_bad, 0);
    check("gap_done_cyc", obs_done_cyc, 47);

    // Three-cycle stall on row 2.
    run_job(2, -1, -1, 1'b0, 45);
    check("stall_row2", obs_stall2, 3);
    check("stall_order", obs_order_bad, 0);
    check("stall_done_cyc", obs_done_cyc, 35);

    // Abort at compute count 5 (cycle 23); cycle 24 shows the aftermath.
    snap_at = 24;
    run_job(0, 23, -1, 1'b0, 40);
    check("abort_done_cnt", obs_dones, 0);
    check("abort_pulses", obs_aborts, 1);
    check("abort_shifts", obs_shifts, 6);
    check("abort_next_cycle", 32'({snap_vec[22], snap_vec[20], snap_vec[5], snap_vec[6]}),
          32'(4'b0110));

    // start held while busy, rst in mid-LOAD, then a fresh job.
    snap_at = 11;
    run_job(0, -1, 10, 1'b1, 20);
    check("rst_outputs_zero", 32'(snap_vec), 32'd0);
    check("rst_no_done", obs_dones, 0);
    check("rst_no_abort", obs_aborts, 0);
    snap_at = -1;
    run_job(0, -1, -1, 1'b0, 40);
    check("fresh_done_cyc", obs_done_cyc, 32);
    check("fresh_order", obs_order_bad, 0);

    for (int j = 0; j < 20; j++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : -1;
      run_job(3, ab, -1, 1'b0, 120);
      check("rand_load_hs", obs_bad_load, 0);
      check("rand_order", obs_order_bad, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
